ex_muldiv_unit: RTL

- Iterative multiply/divide unit in the EX stage, fed by the ID/EX pipeline register outputs (forwarded operands and decoded mul/div opcode).
- Executes MULT/MULTU/DIV/DIVU at one bit per cycle and holds the architectural HI/LO registers.
- Serves MTHI/MTLO writes.
- Exposes busy/done so the hazard unit can stall MFHI/MFLO and further mul/div issue until results are final.

---
 rtl/ex_muldiv_unit_if.sv | 37 +++
 rtl/ex_muldiv_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Bus bundle between the EX stage and the iterative multiply/divide unit.
//
// Handshake: the issuer raises start for one cycle with op/src_a/src_b valid.
// The unit accepts it only while busy=0 (and cancel=0). After acceptance, busy
// stays high until the result is written. done pulses for exactly one cycle,
// in the first cycle that hi/lo carry the new result. There is no ready
// signal: the issuer must treat (busy | start) as "HI/LO not ready" and hold
// off further mul/div issue and MFHI/MFLO. cancel drops an in-flight operation
// without a done pulse. hi_we/lo_we are MTHI/MTLO writes and take effect only
// while idle and not starting.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  modport master (
    output start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
    input  hi, lo, busy, done, state_dbg
  );

  modport slave (
    input  start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
    output hi, lo, busy, done, state_dbg
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with the architectural HI/LO registers.
// One bit per cycle. Multiply uses shift-add and divide uses the restoring
// algorithm. Both work on unsigned magnitudes held in one 2*WIDTH accumulator.
// Signs are applied in the FIX cycle, and the result is written on the edge
// that leaves FIX.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  ex_muldiv_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mag_b_q;
  logic [CW-1:0]        cnt_q;
  logic                 is_div_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 done_q;

  // Issue decode: op[1] selects divide, op[0] selects unsigned.
  logic                 start_ok;
  logic                 op_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 div_zero;

  // Per-cycle step results.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh;
  logic                 div_ge;
  logic [WIDTH-1:0]     rem_sub;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   div_next;

  // Sign-fixed results presented on the FIX exit edge.
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

  // Operand magnitudes at issue. The most negative value maps to 2^(WIDTH-1).
  always_comb begin
    start_ok  = (state_q == S_IDLE) && bus.start && !bus.cancel;
    op_signed = !bus.op[0];
    a_neg     = op_signed && bus.src_a[WIDTH-1];
    b_neg     = op_signed && bus.src_b[WIDTH-1];
    mag_a     = a_neg ? -bus.src_a : bus.src_a;
    mag_b     = b_neg ? -bus.src_b : bus.src_b;
    div_zero  = bus.op[1] && (bus.src_b == '0);
  end

  // One shift-add multiply step and one restoring-divide step, computed
  // from the current accumulator.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_b_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                        : {1'b0, acc_q[2*WIDTH-1:1]};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = rem_sh >= {1'b0, mag_b_q};
    // The difference is always below 2^WIDTH, so a WIDTH-bit subtract is exact.
    rem_sub  = rem_sh[WIDTH-1:0] - mag_b_q;
    rem_new  = div_ge ? rem_sub : rem_sh[WIDTH-1:0];
    div_next = {rem_new, acc_q[WIDTH-2:0], div_ge};
  end

  // Apply the result signs. The flags are cleared at issue for unsigned ops
  // and for divide-by-zero, so those results pass through unchanged.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    res_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. cancel aborts CALC or FIX. Divide-by-zero skips CALC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = div_zero ? S_FIX : S_CALC;
      end
      S_CALC: begin
        if (bus.cancel)                        state_d = S_IDLE;
        else if (cnt_q == CW'(WIDTH - 1))      state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.state_dbg = state_q;
    bus.done      = done_q;
    bus.hi        = hi_q;
    bus.lo        = lo_q;
  end

  // Datapath: latch the operands at issue, then step the accumulator in CALC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      mag_b_q   <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (start_ok) begin
      acc_q     <= div_zero ? {bus.src_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, mag_a};
      mag_b_q   <= mag_b;
      cnt_q     <= '0;
      is_div_q  <= bus.op[1];
      neg_res_q <= !div_zero && (a_neg ^ b_neg);
      neg_rem_q <= !div_zero && a_neg;
    end else if (state_q == S_CALC && !bus.cancel) begin
      acc_q <= is_div_q ? div_next : mul_next;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // HI/LO and done. A completing FIX writes the result and pulses done.
  // MTHI/MTLO are honoured only when idle and not starting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_FIX && !bus.cancel) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        done_q <= 1'b1;
      end else if (state_q == S_IDLE && !bus.start) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

endmodule
